// File: rtl/if_stage_pkg.sv
// Shared fetch-stage definitions: FSM state encodings, reset/NOP constants and
// the word-alignment helper used on redirect targets.
package if_stage_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        HOLD = 2'd1,
        KILL = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] ALIGN_MASK       = 32'hFFFF_FFFC;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ALIGN_MASK;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/response bus. A request completes in the cycle
// where req=1 and ready=1; addr must not change while req=1 and ready=0.
interface if_stage_if;
    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic [31:0] rdata;

    modport master (output req, output addr, input ready, input rdata);
    modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/if_stage_pc_reg.sv
// Program counter with redirect selection, target alignment and +4 stepping.
// A redirect always wins over a sequential advance.
module pc_reg
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        advance,
    output logic        redirect,
    output logic [31:0] pc
);

    logic [31:0] target;

    // Branch beats jump when ID reports both in the same cycle.
    always_comb begin
        redirect = branch_taken | jump;
        target   = branch_taken ? align_word(branch_target) : align_word(jump_target);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= target;
        end else if (advance) begin
            pc <= pc + PC_STEP;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: issues requests, holds a fetched word under stall,
// and discards the in-flight response of a request overtaken by a redirect.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         PCWrite,
    input  logic         branch_taken,
    input  logic [31:0]  branch_target,
    input  logic         jump,
    input  logic [31:0]  jump_target,
    if_stage_if.master   imem,
    output logic [31:0]  IF_inst,
    output logic [31:0]  PC_out,
    output logic         IF_valid,
    output logic         IF_Flush,
    output logic         fetch_busy,
    output fetch_state_e state
);

    logic        redirect;
    logic        advance;
    logic [31:0] pc;
    logic [31:0] buffer;
    logic [31:0] kill_addr;

    pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .clk           (clk),
        .reset         (reset),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .advance       (advance),
        .redirect      (redirect),
        .pc            (pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= REQ;
            buffer    <= '0;
            kill_addr <= '0;
        end else begin
            case (state)
                REQ: begin
                    if (imem.ready) begin
                        if (!redirect && !PCWrite) begin
                            buffer <= imem.rdata;
                            state  <= HOLD;
                        end
                    end else if (redirect) begin
                        // The outstanding request must still be drained at its own address.
                        kill_addr <= pc;
                        state     <= KILL;
                    end
                end
                HOLD: begin
                    if (redirect || PCWrite) begin
                        state <= REQ;
                    end
                end
                KILL: begin
                    if (imem.ready) begin
                        state <= REQ;
                    end
                end
                default: state <= REQ;
            endcase
        end
    end

    // Address depends only on registered state, never on imem.rdata.
    always_comb begin
        imem.req  = 1'b0;
        imem.addr = pc;
        IF_valid  = 1'b0;
        IF_inst   = NOP_INST;
        advance   = 1'b0;
        if (!reset) begin
            case (state)
                REQ: begin
                    imem.req = 1'b1;
                    if (imem.ready && !redirect) begin
                        IF_valid = 1'b1;
                        IF_inst  = imem.rdata;
                        advance  = PCWrite;
                    end
                end
                HOLD: begin
                    advance = PCWrite;
                    if (!redirect) begin
                        IF_valid = 1'b1;
                        IF_inst  = buffer;
                    end
                end
                KILL: begin
                    imem.req  = 1'b1;
                    imem.addr = kill_addr;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        PC_out     = pc;
        IF_Flush   = redirect & ~reset;
        fetch_busy = ((state == REQ) & ~imem.ready) | (state == KILL);
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: each cycle drives inputs on the falling edge and
// compares outputs against hand-computed values before the next rising edge.
module tb_if_stage;
    import if_stage_pkg::*;

    logic         clk;
    logic         reset;
    logic         PCWrite;
    logic         branch_taken;
    logic [31:0]  branch_target;
    logic         jump;
    logic [31:0]  jump_target;
    logic [31:0]  IF_inst;
    logic [31:0]  PC_out;
    logic         IF_valid;
    logic         IF_Flush;
    logic         fetch_busy;
    fetch_state_e dut_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    if_stage_if imem_bus();

    if_stage dut (
        .clk           (clk),
        .reset         (reset),
        .PCWrite       (PCWrite),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .imem          (imem_bus),
        .IF_inst       (IF_inst),
        .PC_out        (PC_out),
        .IF_valid      (IF_valid),
        .IF_Flush      (IF_Flush),
        .fetch_busy    (fetch_busy),
        .state         (dut_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory returns 0xC0DE_<addr[15:0]> when ready, junk otherwise
    always_comb begin
        imem_bus.rdata = imem_bus.ready ? {16'hC0DE, imem_bus.addr[15:0]} : 32'hDEAD_DEAD;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic rdy, input logic pcw,
                         input logic bt, input logic [31:0] btgt,
                         input logic jp, input logic [31:0] jtgt);
        @(negedge clk);
        reset          = rst;
        imem_bus.ready = rdy;
        PCWrite        = pcw;
        branch_taken   = bt;
        branch_target  = btgt;
        jump           = jp;
        jump_target    = jtgt;
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset          = 1'b1;
        imem_bus.ready = 1'b0;
        PCWrite        = 1'b1;
        branch_taken   = 1'b0;
        branch_target  = '0;
        jump           = 1'b0;
        jump_target    = '0;

        // reset with a redirect pending: everything quiet, PC loaded
        drive(1, 1, 1, 1, 32'h0000_3101, 0, 0);
        check("rst_req",   32'(imem_bus.req), 32'd0);
        check("rst_valid", 32'(IF_valid),     32'd0);
        check("rst_inst",  IF_inst,           32'h0000_0000);
        check("rst_flush", 32'(IF_Flush),     32'd0);
        check("rst_pc",    PC_out,            32'h0000_3000);

        // zero-wait streaming: one instruction per cycle
        exp_q.push_back(32'h0000_3000);
        exp_q.push_back(32'h0000_3004);
        exp_q.push_back(32'h0000_3008);
        while (exp_q.size() > 0) begin
            logic [31:0] exp_pc;
            exp_pc = exp_q.pop_front();
            drive(0, 1, 1, 0, 0, 0, 0);
            check("stream_req",   32'(imem_bus.req), 32'd1);
            check("stream_addr",  imem_bus.addr,     exp_pc);
            check("stream_pc",    PC_out,            exp_pc);
            check("stream_valid", 32'(IF_valid),     32'd1);
            check("stream_inst",  IF_inst,           {16'hC0DE, exp_pc[15:0]});
            check("stream_busy",  32'(fetch_busy),   32'd0);
        end

        // stall: word@3004 captured and held, no refetch
        drive(1, 0, 1, 0, 0, 0, 0);
        drive(0, 1, 1, 0, 0, 0, 0);
        check("s38_pc0", PC_out, 32'h0000_3000);
        drive(0, 1, 0, 0, 0, 0, 0);
        check("s38_cap_valid", 32'(IF_valid), 32'd1);
        check("s38_cap_inst",  IF_inst,       32'hC0DE_3004);
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            check("hold_req",   32'(imem_bus.req), 32'd0);
            check("hold_valid", 32'(IF_valid),     32'd1);
            check("hold_inst",  IF_inst,           32'hC0DE_3004);
            check("hold_pc",    PC_out,            32'h0000_3004);
            check("hold_busy",  32'(fetch_busy),   32'd0);
            check("hold_state", 32'(dut_state),    32'(HOLD));
        end
        drive(0, 0, 1, 0, 0, 0, 0);
        check("release_inst", IF_inst,       32'hC0DE_3004);
        check("release_req",  32'(imem_bus.req), 32'd0);

        // miss at 3008 overtaken by a misaligned branch to 3101
        drive(0, 0, 1, 1, 32'h0000_3101, 0, 0);
        check("miss_addr",  imem_bus.addr,     32'h0000_3008);
        check("miss_flush", 32'(IF_Flush),     32'd1);
        check("miss_valid", 32'(IF_valid),     32'd0);
        check("miss_busy",  32'(fetch_busy),   32'd1);
        drive(0, 0, 1, 0, 0, 0, 0);
        check("kill_state", 32'(dut_state),    32'(KILL));
        check("kill_addr",  imem_bus.addr,     32'h0000_3008);
        check("kill_req",   32'(imem_bus.req), 32'd1);
        check("kill_pc",    PC_out,            32'h0000_3100);
        check("kill_flush", 32'(IF_Flush),     32'd0);
        check("kill_busy",  32'(fetch_busy),   32'd1);
        drive(0, 1, 1, 0, 0, 0, 0);
        check("drop_valid", 32'(IF_valid),     32'd0);
        check("drop_inst",  IF_inst,           32'h0000_0000);
        check("drop_busy",  32'(fetch_busy),   32'd1);
        drive(0, 1, 1, 0, 0, 0, 0);
        check("after_kill_addr",  imem_bus.addr, 32'h0000_3100);
        check("after_kill_valid", 32'(IF_valid), 32'd1);
        check("after_kill_inst",  IF_inst,       32'hC0DE_3100);

        // branch and jump together: branch wins
        drive(0, 1, 1, 1, 32'h0000_3200, 1, 32'h0000_3300);
        check("both_flush", 32'(IF_Flush), 32'd1);
        check("both_valid", 32'(IF_valid), 32'd0);
        drive(0, 1, 1, 0, 0, 1, 32'hFFFF_FFFE);
        check("both_pc",   PC_out,        32'h0000_3200);
        check("both_addr", imem_bus.addr, 32'h0000_3200);

        // wrap from FFFF_FFFC to 0
        drive(0, 1, 1, 0, 0, 0, 0);
        check("wrap_pc0",  PC_out,  32'hFFFF_FFFC);
        check("wrap_inst", IF_inst, 32'hC0DE_FFFC);
        drive(0, 0, 1, 0, 0, 1, 32'h0000_3400);
        check("wrap_pc1",   PC_out,            32'h0000_0000);
        check("wrap_flush", 32'(IF_Flush),     32'd1);

        // reset lands in KILL while the response arrives
        drive(0, 0, 1, 0, 0, 0, 0);
        check("k2_state", 32'(dut_state), 32'(KILL));
        check("k2_addr",  imem_bus.addr,  32'h0000_0000);
        check("k2_pc",    PC_out,         32'h0000_3400);
        drive(1, 1, 1, 0, 0, 0, 0);
        check("k2_rst_req",   32'(imem_bus.req), 32'd0);
        check("k2_rst_valid", 32'(IF_valid),     32'd0);
        check("k2_rst_inst",  IF_inst,           32'h0000_0000);
        drive(0, 1, 1, 0, 0, 0, 0);
        check("k2_post_state", 32'(dut_state),   32'(REQ));
        check("k2_post_addr",  imem_bus.addr,    32'h0000_3000);
        check("k2_post_valid", 32'(IF_valid),    32'd1);
        check("k2_post_inst",  IF_inst,          32'hC0DE_3000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
